// File: rtl/router_pkg.sv
// Shared types for the router output allocator.
package router_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } alloc_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: picks the first set request at or after ptr, wrapping
// modulo NUM_INPUTS. Pure combinational; returns a one-hot grant and its index.
module rr_arbiter #(
   parameter int NUM_INPUTS = 5,
   parameter int IDX_WIDTH  = $clog2(NUM_INPUTS)
) (
   input  logic [NUM_INPUTS-1:0] req,
   input  logic [IDX_WIDTH-1:0]  ptr,
   output logic [NUM_INPUTS-1:0] grant,
   output logic [IDX_WIDTH-1:0]  idx
);

   logic [IDX_WIDTH:0]   sum;
   logic [IDX_WIDTH-1:0] pos;
   logic                 found;

   always_comb begin
      grant = '0;
      idx   = '0;
      sum   = '0;
      pos   = '0;
      found = 1'b0;
      for (int off = 0; off < NUM_INPUTS; off++) begin
         sum = {1'b0, ptr} + (IDX_WIDTH+1)'(off);
         if (sum >= (IDX_WIDTH+1)'(NUM_INPUTS)) begin
            sum = sum - (IDX_WIDTH+1)'(NUM_INPUTS);
         end
         pos = sum[IDX_WIDTH-1:0];
         if (!found && req[pos]) begin
            found      = 1'b1;
            grant[pos] = 1'b1;
            idx        = pos;
         end
      end
   end

endmodule

// File: rtl/router_output_allocator.sv
// Wormhole output allocator: round-robin between inputs, lock held until tail,
// credit-based flow control. Optional statistics via ROUTER_OUTPUT_ALLOC_STATS_EN.
module router_output_allocator
   import router_pkg::*;
#(
   parameter  int NUM_INPUTS        = 5,
   parameter  int FLIT_BUFFER_DEPTH = 8,
   localparam int CNT_WIDTH         = $clog2(FLIT_BUFFER_DEPTH+1),
   localparam int IDX_WIDTH         = $clog2(NUM_INPUTS)
) (
   input  logic                  clk_noc,
   input  logic                  rst_noc_sync,
   input  logic [NUM_INPUTS-1:0] req_in,
   input  logic [NUM_INPUTS-1:0] tail_in,
   input  logic [NUM_INPUTS-1:0] turn_disable,
   input  logic                  credit_in,
   output logic [NUM_INPUTS-1:0] grant_out,
   output logic                  send_out,
   output logic [IDX_WIDTH-1:0]  owner_out,
   output logic [CNT_WIDTH-1:0]  credit_cnt_out,
   output logic                  credit_err_out
`ifdef ROUTER_OUTPUT_ALLOC_STATS_EN
   ,
   output logic [31:0]           flit_cnt_out,
   output logic [31:0]           stall_cnt_out
`endif
);

   localparam logic [CNT_WIDTH-1:0] CREDIT_MAX = CNT_WIDTH'(FLIT_BUFFER_DEPTH);

   alloc_state_t          state, state_nxt;
   logic [IDX_WIDTH-1:0]  rr_ptr, rr_ptr_nxt;
   logic [IDX_WIDTH-1:0]  owner, owner_nxt;
   logic [CNT_WIDTH-1:0]  credit_cnt;
   logic                  credit_err;

   logic [NUM_INPUTS-1:0] eligible;
   logic [NUM_INPUTS-1:0] arb_grant;
   logic [IDX_WIDTH-1:0]  arb_idx;
   logic [NUM_INPUTS-1:0] owner_oh;
   logic [NUM_INPUTS-1:0] grant;
   logic [IDX_WIDTH-1:0]  win_idx;
   logic                  owner_req;
   logic                  credit_ok;
   logic                  send;
   logic                  win_tail;

   function automatic logic [IDX_WIDTH-1:0] next_idx(input logic [IDX_WIDTH-1:0] cur);
      if (cur == IDX_WIDTH'(NUM_INPUTS-1)) begin
         return '0;
      end
      return cur + 1'b1;
   endfunction

   // The turn mask only filters new arbitration; an established owner ignores it.
   assign eligible  = req_in & ~turn_disable;
   assign credit_ok = (credit_cnt != '0);

   always_comb begin
      owner_oh = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         owner_oh[i] = (owner == IDX_WIDTH'(i));
      end
   end

   assign owner_req = |(req_in & owner_oh);

   rr_arbiter #(
      .NUM_INPUTS (NUM_INPUTS),
      .IDX_WIDTH  (IDX_WIDTH)
   ) u_rr_arbiter (
      .req   (eligible),
      .ptr   (rr_ptr),
      .grant (arb_grant),
      .idx   (arb_idx)
   );

   always_ff @(posedge clk_noc) begin
      if (rst_noc_sync) begin
         state  <= IDLE;
         rr_ptr <= '0;
         owner  <= '0;
      end else begin
         state  <= state_nxt;
         rr_ptr <= rr_ptr_nxt;
         owner  <= owner_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      rr_ptr_nxt = rr_ptr;
      owner_nxt  = owner;
      grant      = '0;
      win_idx    = (state == IDLE) ? arb_idx : owner;
      // A credit arriving this cycle is not usable until the next one.
      if (!rst_noc_sync && credit_ok) begin
         case (state)
            IDLE:    grant = arb_grant;
            LOCKED:  grant = owner_req ? owner_oh : '0;
            default: grant = '0;
         endcase
      end
      send     = |grant;
      win_tail = |(tail_in & grant);
      if (send) begin
         owner_nxt = win_idx;
         if (win_tail) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = next_idx(win_idx);
         end else begin
            state_nxt  = LOCKED;
         end
      end
   end

   always_ff @(posedge clk_noc) begin
      if (rst_noc_sync) begin
         credit_cnt <= CREDIT_MAX;
         credit_err <= 1'b0;
      end else begin
         case ({send, credit_in})
            2'b10: credit_cnt <= credit_cnt - 1'b1;
            2'b01: begin
               if (credit_cnt == CREDIT_MAX) begin
                  credit_err <= 1'b1;
               end else begin
                  credit_cnt <= credit_cnt + 1'b1;
               end
            end
            default: credit_cnt <= credit_cnt;
         endcase
      end
   end

   assign grant_out      = grant;
   assign send_out       = send;
   assign owner_out      = owner;
   assign credit_cnt_out = credit_cnt;
   assign credit_err_out = credit_err;

`ifdef ROUTER_OUTPUT_ALLOC_STATS_EN
   logic        stall;
   logic [31:0] flit_cnt;
   logic [31:0] stall_cnt;

   assign stall = !credit_ok && ((state == IDLE) ? |eligible : owner_req);

   always_ff @(posedge clk_noc) begin
      if (rst_noc_sync) begin
         flit_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         if (send) begin
            flit_cnt <= flit_cnt + 32'd1;
         end
         if (stall) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
      end
   end

   assign flit_cnt_out  = flit_cnt;
   assign stall_cnt_out = stall_cnt;
`endif

endmodule

// File: doc/router_output_allocator.md
ROUTER_OUTPUT_ALLOCATOR -- requirements
Module: router_output_allocator

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 5: number of router input ports competing for this output.
REQ-002 SHALL have parameter FLIT_BUFFER_DEPTH, default 8: downstream buffer depth, which is also the initial and maximum credit count.
REQ-003 SHALL have localparam CNT_WIDTH = $clog2(FLIT_BUFFER_DEPTH+1) and localparam IDX_WIDTH = $clog2(NUM_INPUTS).
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk_noc  input  1  NoC clock; all state updates on its rising edge.
REQ-006 rst_noc_sync  input  1  synchronous active-high reset.
REQ-007 req_in  input  NUM_INPUTS  input i holds a flit routed to this output.
REQ-008 tail_in  input  NUM_INPUTS  the head flit of input i is a tail.
REQ-009 turn_disable  input  NUM_INPUTS  static mask; a set bit means input i never wins.
REQ-010 credit_in  input  1  downstream returned one buffer slot.
REQ-011 grant_out  output  NUM_INPUTS  one-hot or zero; pops the winning input's flit in the same cycle.
REQ-012 send_out  output  1  a flit is forwarded this cycle; equals OR of grant_out.
REQ-013 owner_out  output  IDX_WIDTH  index of the current or most recent winner.
REQ-014 credit_cnt_out  output  CNT_WIDTH  current credit count.
REQ-015 credit_err_out  output  1  sticky flag: a credit arrived while the count was already at maximum.

Function
REQ-016 SHALL use an FSM with two states: IDLE (no packet owns the output) and LOCKED (a wormhole packet owns it).
REQ-017 In IDLE, SHALL grant the first eligible input at or after rr_ptr, wrapping modulo NUM_INPUTS; eligible = req_in & ~turn_disable, with credit count > 0.
REQ-018 In LOCKED, SHALL grant only the input in owner, and only when req_in[owner] is set and credit count > 0; requests from other inputs are ignored.
REQ-019 IDLE→LOCKED on a grant whose tail_in is 0; owner <= the winner.
REQ-020 A grant with tail_in 1 in IDLE (single-flit packet) SHALL leave the FSM in IDLE, with rr_ptr <= winner+1 (mod NUM_INPUTS).
REQ-021 LOCKED→IDLE on a grant to owner with tail_in 1; rr_ptr <= owner+1 (mod NUM_INPUTS).
REQ-022 grant_out and send_out SHALL be combinational from current state and inputs: zero-cycle arbitration latency, one flit per cycle maximum.
REQ-023 Credit counter: send only → decrement; credit_in only → increment; both in the same cycle → unchanged; neither → unchanged.
REQ-024 A credit_in with the count at FLIT_BUFFER_DEPTH and no send SHALL saturate the count and set credit_err_out.
REQ-025 When the count is 0, SHALL assert no grant, even if a credit_in arrives in that same cycle; the returned credit is usable in the next cycle.
REQ-026 A turn_disable bit set on the current owner while LOCKED SHALL NOT break the lock; the mask applies only to new arbitration.

Reset
REQ-027 While rst_noc_sync is high at a clock edge, SHALL set state=IDLE, rr_ptr=0, owner=0, credit count=FLIT_BUFFER_DEPTH, credit_err_out=0.
REQ-028 While in reset, grant_out and send_out SHALL be 0.
REQ-029 A reset asserted mid-packet SHALL abandon the lock with no further grants; the credit count reloads to FLIT_BUFFER_DEPTH.

Configuration
REQ-030 With macro ROUTER_OUTPUT_ALLOC_STATS_EN defined, SHALL add outputs flit_cnt_out[31:0] and stall_cnt_out[31:0].
REQ-031 flit_cnt_out SHALL count send cycles; stall_cnt_out SHALL count cycles with a request from an eligible input or owner but credit count = 0.
REQ-032 Both counters SHALL be cleared by reset and SHALL wrap modulo 2^32.
REQ-033 Without ROUTER_OUTPUT_ALLOC_STATS_EN, these ports and their logic SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-034 The alloc_state_t enum (IDLE, LOCKED) SHALL live in shared package router_pkg.
REQ-035 Round-robin selection SHALL be one sub-module, rr_arbiter (inputs: request vector, pointer; outputs: one-hot grant, index).
REQ-036 Credit counter and FSM SHALL be implemented in this module.

Verification
REQ-037 After reset, req_in=00001 with tail=1 → grant_out=00001 in that cycle, credit 8→7, state stays IDLE.
REQ-038 Inputs 1 and 3 request 3-flit packets simultaneously, rr_ptr=0 → input 1 gets 3 consecutive grants, then input 3; no interleaving.
REQ-039 Send 8 flits with no credit_in → credit_cnt_out=0 and grant_out=0 while requests persist; one credit_in → exactly one grant in the next cycle.
REQ-040 Send and credit_in in the same cycle at count 5 → count stays 5.
REQ-041 credit_in with count=8 → count stays 8, credit_err_out=1 until reset.
REQ-042 Reset after the head flit of a 4-flit packet → state IDLE, count=8, a new requester is granted by round-robin from index 0.
